// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch-penalty
// flushes and whole-pipeline freeze while data memory is busy, plus debug counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_W        = 5,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned MAX_WAIT     = 64,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             branch_taken,
  input  logic             mem_stall_req,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  localparam int unsigned REM_W  = 3;
  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    BR_FLUSH = 2'd1,
    MEM_WAIT = 2'd2,
    ILLEGAL  = 2'd3
  } state_t;

  state_t            state_q, state_nxt, decode_st;
  logic [REM_W-1:0]  rem_q, rem_nxt;
  logic [WAIT_W-1:0] wait_q, wait_nxt;
  logic              ret_q, ret_nxt;
  logic              stall_inc, flush_inc;
  logic              hz;

  assign hz = ex_mem_read & (ex_rt != '0) &
              ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));

  assign state = state_q;

  // Next-state and same-cycle control decode
  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    idex_write  = 1'b0;
    exmem_write = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    state_nxt   = state_q;
    rem_nxt     = rem_q;
    wait_nxt    = wait_q;
    ret_nxt     = ret_q;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    decode_st   = state_q;

    // Leaving MEM_WAIT decodes as the state being returned to, in the same cycle
    if (state_q == MEM_WAIT && !mem_stall_req) begin
      decode_st = ret_q ? BR_FLUSH : RUN;
      wait_nxt  = '0;
      ret_nxt   = 1'b0;
    end

    case (decode_st)
      RUN: begin
        if (mem_stall_req) begin
          state_nxt = MEM_WAIT;
          wait_nxt  = WAIT_W'(1);
          ret_nxt   = 1'b0;
        end else if (branch_taken) begin
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          idex_write  = 1'b1;
          exmem_write = 1'b1;
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          flush_inc   = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_nxt = BR_FLUSH;
            rem_nxt   = REM_W'(FLUSH_CYCLES - 1);
          end else begin
            state_nxt = RUN;
          end
        end else if (hz) begin
          idex_write  = 1'b1;
          exmem_write = 1'b1;
          idex_bubble = 1'b1;
          stall_inc   = 1'b1;
          state_nxt   = RUN;
        end else begin
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          idex_write  = 1'b1;
          exmem_write = 1'b1;
          state_nxt   = RUN;
        end
      end
      BR_FLUSH: begin
        if (mem_stall_req) begin
          state_nxt = MEM_WAIT;
          wait_nxt  = WAIT_W'(1);
          ret_nxt   = 1'b1;
        end else begin
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          idex_write  = 1'b1;
          exmem_write = 1'b1;
          ifid_flush  = 1'b1;
          flush_inc   = 1'b1;
          rem_nxt     = rem_q - REM_W'(1);
          state_nxt   = (rem_q == REM_W'(1)) ? RUN : BR_FLUSH;
        end
      end
      MEM_WAIT: begin
        wait_nxt = (wait_q >= WAIT_W'(MAX_WAIT)) ? wait_q : wait_q + WAIT_W'(1);
      end
      default: state_nxt = RUN;
    endcase

    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
      idex_bubble = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
    end
  end

  // State, sequencing counters and saturating debug counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      rem_q       <= '0;
      wait_q      <= '0;
      ret_q       <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state_q <= state_nxt;
      rem_q   <= rem_nxt;
      wait_q  <= wait_nxt;
      ret_q   <= ret_nxt;
      if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
      if (wait_nxt >= WAIT_W'(MAX_WAIT)) mem_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized + directed bench for pipeline_hazard_ctrl against a cycle-level
// behavioural model derived from the hazard/flush/wait rules.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned REG_W = 5;
  localparam int unsigned FC    = 2;
  localparam int unsigned MAXW  = 64;
  localparam int unsigned CNT_W = 2;
  localparam int          CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [REG_W-1:0] id_rs, id_rt, ex_rt;
  logic             id_uses_rt, ex_mem_read, branch_taken, mem_stall_req;
  logic             pc_write, ifid_write, idex_write, exmem_write;
  logic             idex_bubble, ifid_flush, idex_flush, mem_timeout;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  pipeline_hazard_ctrl #(
    .REG_W(REG_W), .FLUSH_CYCLES(FC), .MAX_WAIT(MAXW), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .branch_taken(branch_taken), .mem_stall_req(mem_stall_req),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .idex_bubble(idex_bubble),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .mem_timeout(mem_timeout)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: phase 0=running, 1=branch penalty, 2=waiting on memory
  int m_st, m_rem, m_wait, m_sc, m_fc;
  bit m_ret, m_to;
  int n_st, n_rem, n_wait, n_sc, n_fc;
  bit n_ret, n_to;
  bit e_pc, e_ifid, e_idex, e_exmem, e_bub, e_iff, e_idf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? v : v + 1;
  endfunction

  task automatic all_en(input bit v);
    e_pc = v; e_ifid = v; e_idex = v; e_exmem = v;
  endtask

  task automatic model_eval();
    int  ph;
    bit  hz;
    hz = ex_mem_read && (ex_rt != 0) &&
         ((ex_rt == id_rs) || (id_uses_rt && ex_rt == id_rt));
    all_en(0); e_bub = 0; e_iff = 0; e_idf = 0;
    n_st = m_st; n_rem = m_rem; n_wait = m_wait; n_ret = m_ret;
    n_sc = m_sc; n_fc = m_fc; n_to = m_to;
    if (reset) begin
      e_iff = 1; e_idf = 1;
      n_st = 0; n_rem = 0; n_wait = 0; n_ret = 0; n_sc = 0; n_fc = 0; n_to = 0;
      return;
    end
    ph = m_st;
    if (m_st == 2 && !mem_stall_req) begin
      ph = m_ret ? 1 : 0; n_wait = 0; n_ret = 0;
    end
    if (ph == 2) begin
      n_wait = (m_wait + 1 > int'(MAXW)) ? int'(MAXW) : m_wait + 1;
    end else if (ph == 3) begin
      n_st = 0;
    end else if (mem_stall_req) begin
      n_st = 2; n_wait = 1; n_ret = (ph == 1);
    end else if (ph == 1) begin
      all_en(1); e_iff = 1; n_fc = sat_inc(m_fc);
      n_rem = m_rem - 1; n_st = (n_rem == 0) ? 0 : 1;
    end else if (branch_taken) begin
      all_en(1); e_iff = 1; e_idf = 1; n_fc = sat_inc(m_fc);
      if (FC > 1) begin n_st = 1; n_rem = FC - 1; end else n_st = 0;
    end else if (hz) begin
      e_idex = 1; e_exmem = 1; e_bub = 1; n_sc = sat_inc(m_sc); n_st = 0;
    end else begin
      all_en(1); n_st = 0;
    end
    if (n_wait >= int'(MAXW)) n_to = 1;
  endtask

  task automatic set_in(input int rs, input int rt, input bit urt, input bit mr,
                        input int xrt, input bit br, input bit mem);
    id_rs = REG_W'(rs); id_rt = REG_W'(rt); id_uses_rt = urt;
    ex_mem_read = mr; ex_rt = REG_W'(xrt); branch_taken = br; mem_stall_req = mem;
  endtask

  // One cycle: compare everything before the edge, then advance the model
  task automatic step();
    #1;
    model_eval();
    check_eq("pc_write",    32'(pc_write),    32'(e_pc));
    check_eq("ifid_write",  32'(ifid_write),  32'(e_ifid));
    check_eq("idex_write",  32'(idex_write),  32'(e_idex));
    check_eq("exmem_write", 32'(exmem_write), 32'(e_exmem));
    check_eq("idex_bubble", 32'(idex_bubble), 32'(e_bub));
    check_eq("ifid_flush",  32'(ifid_flush),  32'(e_iff));
    check_eq("idex_flush",  32'(idex_flush),  32'(e_idf));
    check_eq("state",       32'(state),       32'(m_st));
    check_eq("stall_cnt",   32'(stall_cnt),   32'(m_sc));
    check_eq("flush_cnt",   32'(flush_cnt),   32'(m_fc));
    check_eq("mem_timeout", 32'(mem_timeout), 32'(m_to));
    @(posedge clk);
    m_st = n_st; m_rem = n_rem; m_wait = n_wait; m_ret = n_ret;
    m_sc = n_sc; m_fc = n_fc; m_to = n_to;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0);
      step();
    end
  endtask

  initial begin
    int burst;
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    m_st = 0; m_rem = 0; m_wait = 0; m_ret = 0; m_sc = 0; m_fc = 0; m_to = 0;
    step();
    reset = 1'b0;
    idle(2);

    // Load-use, then the two non-hazard variants
    set_in(5, 0, 0, 1, 5, 0, 0); step();
    check_eq("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    set_in(0, 0, 0, 1, 0, 0, 0); step();
    set_in(1, 5, 0, 1, 5, 0, 0); step();
    set_in(1, 5, 1, 1, 5, 0, 0); step();
    idle(1);

    // Branch penalty, then reset held mid-penalty
    reset = 1'b1; step(); reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 1, 0); step();
    idle(2);
    check_eq("br_flush_cnt", 32'(flush_cnt), 32'd2);
    set_in(0, 0, 0, 0, 0, 1, 0); step();
    reset = 1'b1; idle(2); reset = 1'b0;
    check_eq("rst_state", 32'(state), 32'd0);

    // Branch with hazard; memory stall with branch
    set_in(3, 0, 0, 1, 3, 1, 0); step();
    idle(2);
    set_in(0, 0, 0, 0, 0, 1, 1); step(); step();
    set_in(0, 0, 0, 0, 0, 1, 0); step();
    idle(3);

    // Stall arriving mid-penalty resumes the penalty afterwards
    set_in(0, 0, 0, 0, 0, 1, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 1); step(); step();
    idle(3);

    // Short and long memory waits
    set_in(0, 0, 0, 0, 0, 0, 1); step(); step(); step();
    idle(2);
    for (int i = 0; i < 70; i++) begin set_in(0, 0, 0, 0, 0, 0, 1); step(); end
    idle(3);
    check_eq("timeout_sticky", 32'(mem_timeout), 32'd1);

    // Counter saturation
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 5; i++) begin set_in(7, 0, 0, 1, 7, 0, 0); step(); end
    check_eq("stall_sat", 32'(stall_cnt), 32'(CMAX));

    // Randomized traffic
    burst = 0;
    for (int i = 0; i < 4000; i++) begin
      bit mem;
      reset = ($urandom_range(0, 299) == 0);
      if (burst > 0) begin
        mem = 1; burst--;
      end else if ($urandom_range(0, 14) == 0) begin
        mem = 1;
        burst = ($urandom_range(0, 19) == 0) ? 70 : int'($urandom_range(0, 6));
      end else begin
        mem = 0;
      end
      set_in(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom),
             1'($urandom), int'($urandom_range(0, 3)),
             ($urandom_range(0, 7) == 0), mem);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
